// File: rtl/pool_window_buffer.sv
// Regroups a raster pixel stream into non-overlapping 2x2 windows for a max-pooling stage.
// Window appears 1 cycle after its last pixel is accepted; no backpressure, in_valid gaps just stall.
module pool_window_buffer #(
  parameter int In_d_W = 8,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [In_d_W-1:0] in_data,
  output logic [In_d_W-1:0] A0,
  output logic [In_d_W-1:0] A1,
  output logic [In_d_W-1:0] A2,
  output logic [In_d_W-1:0] A3,
  output logic              win_valid,
  output logic              frame_done
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [In_d_W-1:0] held;
  logic [In_d_W-1:0] line_buf [IMG_W];

  logic              col_last;
  logic              row_last;
  logic [CW-1:0]     col_even;

  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  // Left column of the current window: the odd column with its LSB cleared.
  assign col_even = col & ~CW'(1);

  // Even rows fill the line buffer; odd rows only read it, so it is never cleared.
  always_ff @(posedge clk) begin
    if (rst && in_valid && !row[0]) begin
      line_buf[col] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      held       <= '0;
      A0         <= '0;
      A1         <= '0;
      A2         <= '0;
      A3         <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end

        if (row[0]) begin
          if (!col[0]) begin
            held <= in_data;
          end else begin
            A0         <= line_buf[col_even];
            A1         <= line_buf[col];
            A2         <= held;
            A3         <= in_data;
            win_valid  <= 1'b1;
            frame_done <= row_last && col_last;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_window_buffer.sv
// Directed and randomized raster streams for pool_window_buffer (4x4 map), checked against a frame-array reference.
module tb_pool_window_buffer;

  localparam int W  = 8;
  localparam int IW = 4;
  localparam int IH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] A0, A1, A2, A3;
  logic         win_valid, frame_done;

  pool_window_buffer #(.In_d_W(W), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .A0(A0), .A1(A1), .A2(A2), .A3(A3),
    .win_valid(win_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pixels stored by (row, col) position in the frame.
  logic [W-1:0] pix [IH][IW];
  int           mr = 0;
  int           mc = 0;
  logic [W-1:0] ea0 = '0, ea1 = '0, ea2 = '0, ea3 = '0;
  logic         ewv = 1'b0, efd = 1'b0;
  int           windows_seen = 0;
  int           frames_seen = 0;
  logic [W-1:0] cpat [16];

  function automatic logic [W-1:0] max4(input logic [W-1:0] a, b, c, d);
    logic [W-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".win_valid"}, 32'(win_valid), 32'(ewv));
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(efd));
    chk({tag, ".A0"}, 32'(A0), 32'(ea0));
    chk({tag, ".A1"}, 32'(A1), 32'(ea1));
    chk({tag, ".A2"}, 32'(A2), 32'(ea2));
    chk({tag, ".A3"}, 32'(A3), 32'(ea3));
    if (ewv) chk({tag, ".pooled_max"}, 32'(max4(A0, A1, A2, A3)), 32'(max4(ea0, ea1, ea2, ea3)));
  endtask

  // One clock: drive inputs, let the edge happen, update the model, compare 1 time unit later.
  task automatic step(input logic v, input logic [W-1:0] d, input string tag);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    ewv = 1'b0;
    efd = 1'b0;
    if (v && rst) begin
      pix[mr][mc] = d;
      if ((mr % 2 == 1) && (mc % 2 == 1)) begin
        ea0 = pix[mr-1][mc-1];
        ea1 = pix[mr-1][mc];
        ea2 = pix[mr][mc-1];
        ea3 = pix[mr][mc];
        ewv = 1'b1;
        efd = (mr == IH - 1) && (mc == IW - 1);
        windows_seen++;
        if (efd) frames_seen++;
      end
      mc++;
      if (mc == IW) begin
        mc = 0;
        mr = (mr + 1) % IH;
      end
    end
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), tag);
  endtask

  task automatic frame(input int base, input int gap, input string tag);
    for (int i = 0; i < IW * IH; i++) begin
      step(1'b1, W'(base + i), tag);
      idle(gap, tag);
    end
  endtask

  // Assert reset between edges, clock a few cycles with in_valid high, release between edges.
  task automatic do_reset(input int cycles, input string tag);
    rst = 1'b0;
    #2;
    mr = 0; mc = 0;
    ea0 = '0; ea1 = '0; ea2 = '0; ea3 = '0;
    ewv = 1'b0; efd = 1'b0;
    check_outputs({tag, ".async"});
    for (int i = 0; i < cycles; i++) step(1'b1, W'($urandom), {tag, ".held"});
    rst = 1'b1;
  endtask

  initial begin
    in_valid = 1'b1;
    in_data  = 8'hA5;
    #3;
    ea0 = '0; ea1 = '0; ea2 = '0; ea3 = '0;
    check_outputs("reset_state");
    step(1'b1, 8'h5A, "reset_ignore_valid");
    #2;
    rst = 1'b1;
    idle(2, "post_reset_idle");

    frame(1, 0, "b2b_frame");
    chk("b2b_window_count", 32'(windows_seen), 32'd4);

    frame(1, 3, "gapped_frame");

    frame(1, 0, "two_frames_a");
    frame(101, 0, "two_frames_b");
    chk("two_frames_done_count", 32'(frames_seen), 32'd4);

    for (int i = 0; i < 7; i++) step(1'b1, W'(200 + i), "abort_frame");
    do_reset(3, "mid_frame_reset");
    frame(1, 0, "after_reset_frame");

    cpat = '{8'hFF, 8'h00, 8'h00, 8'hFF,
             8'h00, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00,
             8'hFF, 8'h00, 8'h00, 8'hFF};
    for (int i = 0; i < 16; i++) step(1'b1, cpat[i], "corner_frame");
    for (int i = 0; i < 16; i++) step(1'b1, 8'h00, "all_zero_frame");
    for (int i = 0; i < 16; i++) step(1'b1, 8'hFF, "all_ff_frame");
    for (int i = 0; i < 16; i++) step(1'b1, ~cpat[i], "inv_corner_frame");

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < IW * IH; i++) begin
        idle($urandom_range(0, 2), "rand_gap");
        step(1'b1, W'($urandom), "rand_pixel");
        if (f == 3 && i == 9) do_reset(1, "rand_reset");
      end
    end
    idle(3, "tail_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
